// File: rtl/branch_pkg.sv
// Shared constants and helpers for the branch unit: condition codes, counter states, condition evaluation.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package branch_pkg;

  localparam logic [2:0] COND_NE     = 3'b000;
  localparam logic [2:0] COND_EQ     = 3'b001;
  localparam logic [2:0] COND_GT     = 3'b010;
  localparam logic [2:0] COND_LT     = 3'b011;
  localparam logic [2:0] COND_GE     = 3'b100;
  localparam logic [2:0] COND_LE     = 3'b101;
  localparam logic [2:0] COND_OV     = 3'b110;
  localparam logic [2:0] COND_ALWAYS = 3'b111;

  localparam logic [1:0] CNT_SNT = 2'b00;
  localparam logic [1:0] CNT_WNT = 2'b01;
  localparam logic [1:0] CNT_WT  = 2'b10;
  localparam logic [1:0] CNT_ST  = 2'b11;

  // flags are {Z,V,N}
  function automatic logic cond_eval(input logic [2:0] cond, input logic [2:0] flags);
    logic z;
    logic v;
    logic n;
    logic res;
    z = flags[2];
    v = flags[1];
    n = flags[0];
    case (cond)
      COND_NE: res = ~z;
      COND_EQ: res = z;
      COND_GT: res = ~z & ~n;
      COND_LT: res = n;
      COND_GE: res = ~n;
      COND_LE: res = n | z;
      COND_OV: res = v;
      default: res = 1'b1;
    endcase
    return res;
  endfunction

  // Saturating 2-bit counter step toward taken / not-taken
  function automatic logic [1:0] counterStep(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken && cnt != CNT_ST) res = cnt + 2'b01;
    else if (!taken && cnt != CNT_SNT) res = cnt - 2'b01;
    return res;
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB with 2-bit counters; one lookup port, one update port, one invalidate port (word addresses).
// Latency: lookup combinational; writes land at the rising edge, so a same-cycle lookup sees old contents.
// Backpressure: none; an update or clear presented in a cycle is always applied.
module branch_target_buffer
  import branch_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int BTB_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-2:0] lookupAddr,
  output logic             lookupTaken,
  output logic [WIDTH-1:0] lookupTarget,
  input  logic             updateEn,
  input  logic [WIDTH-2:0] updateAddr,
  input  logic             updateTaken,
  input  logic [WIDTH-1:0] updateTarget,
  input  logic             clearEn,
  input  logic [WIDTH-2:0] clearAddr
);

  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = WIDTH - 1 - IDX_W;

  logic [BTB_DEPTH-1:0] validMem;
  logic [TAG_W-1:0]     tagMem    [BTB_DEPTH];
  logic [WIDTH-1:0]     targetMem [BTB_DEPTH];
  logic [1:0]           cntMem    [BTB_DEPTH];

  logic [IDX_W-1:0] lookIdx;
  logic [TAG_W-1:0] lookTag;
  logic [IDX_W-1:0] updIdx;
  logic [TAG_W-1:0] updTag;
  logic [IDX_W-1:0] clrIdx;
  logic             updHit;

  assign lookIdx = lookupAddr[IDX_W-1:0];
  assign lookTag = lookupAddr[WIDTH-2:IDX_W];
  assign updIdx  = updateAddr[IDX_W-1:0];
  assign updTag  = updateAddr[WIDTH-2:IDX_W];
  assign clrIdx  = clearAddr[IDX_W-1:0];

  // Fetch-side and update-side hit detection
  always_comb begin
    lookupTaken  = validMem[lookIdx] && (tagMem[lookIdx] == lookTag) && cntMem[lookIdx][1];
    lookupTarget = targetMem[lookIdx];
    updHit       = validMem[updIdx] && (tagMem[updIdx] == updTag);
  end

  // Valid bits: reset clears all, a taken miss allocates, an aliasing non-branch invalidates
  always_ff @(posedge clk) begin
    if (rst) begin
      validMem <= '0;
    end else if (updateEn && (updHit || updateTaken)) begin
      validMem[updIdx] <= 1'b1;
    end else if (clearEn) begin
      validMem[clrIdx] <= 1'b0;
    end
  end

  // Entry payload: train counter on hit, allocate weakly-taken on a taken miss
  always_ff @(posedge clk) begin
    if (updateEn) begin
      if (updHit) begin
        cntMem[updIdx] <= counterStep(cntMem[updIdx], updateTaken);
        if (updateTaken) targetMem[updIdx] <= updateTarget;
      end else if (updateTaken) begin
        tagMem[updIdx]    <= updTag;
        targetMem[updIdx] <= updateTarget;
        cntMem[updIdx]    <= CNT_WT;
      end
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Fetch PC owner: BTB-predicted next PC, EX branch resolution, misprediction redirect and flush.
// Latency: prediction 0 cycles (comb on fetch_pc); redirect lands on the edge after the mispredict cycle.
// Backpressure: stall holds fetch_pc, but a mispredict redirect always overrides it.
module branch_predict_unit
  import branch_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter int               IMM_W     = 9,
  parameter int               BTB_DEPTH = 8,
  parameter logic [WIDTH-1:0] RESET_PC  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  output logic [WIDTH-1:0] fetch_pc,
  output logic             pred_taken,
  output logic [WIDTH-1:0] pred_target,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_use_reg,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic [2:0]       ex_cond,
  input  logic [2:0]       ex_flags,
  input  logic [IMM_W-1:0] ex_imm,
  input  logic [WIDTH-1:0] ex_reg_target,
  input  logic             ex_pred_taken,
  input  logic [WIDTH-1:0] ex_pred_target,
  output logic             flush
);

  localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(2);

  logic [WIDTH-1:0] fetchPcQ;
  logic [WIDTH-1:0] nextPc;
  logic [WIDTH-1:0] seqPc;
  logic [WIDTH-1:0] immOffset;
  logic [WIDTH-1:0] immTarget;
  logic [WIDTH-1:0] resolvedTarget;
  logic [WIDTH-1:0] redirectPc;
  logic             condTrue;
  logic             actualTaken;
  logic             mispredict;
  logic             btbUpdateEn;
  logic             btbClearEn;

  // Word offset shifted to a byte offset; sign-extended to full width
  assign immOffset = {{(WIDTH-IMM_W-1){ex_imm[IMM_W-1]}}, ex_imm, 1'b0};
  assign seqPc     = ex_pc + PC_STEP;
  assign immTarget = seqPc + immOffset;

  // Resolve the EX instruction; non-branches predicted taken are aliasing hits and also redirect
  always_comb begin
    condTrue       = ex_use_reg | cond_eval(ex_cond, ex_flags);
    resolvedTarget = ex_use_reg ? ex_reg_target : immTarget;
    actualTaken    = ex_valid & ex_is_branch & condTrue;
    mispredict     = 1'b0;
    if (ex_valid) begin
      if (ex_is_branch) begin
        mispredict = (actualTaken != ex_pred_taken)
                   | (actualTaken & (resolvedTarget != ex_pred_target));
      end else begin
        mispredict = ex_pred_taken;
      end
    end
    redirectPc = actualTaken ? resolvedTarget : seqPc;
  end

  assign btbUpdateEn = ex_valid & ex_is_branch & ~ex_use_reg;
  assign btbClearEn  = ex_valid & ~ex_is_branch & ex_pred_taken;

  branch_target_buffer #(
    .WIDTH     (WIDTH),
    .BTB_DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk          (clk),
    .rst          (rst),
    .lookupAddr   (fetchPcQ[WIDTH-1:1]),
    .lookupTaken  (pred_taken),
    .lookupTarget (pred_target),
    .updateEn     (btbUpdateEn),
    .updateAddr   (ex_pc[WIDTH-1:1]),
    .updateTaken  (actualTaken),
    .updateTarget (resolvedTarget),
    .clearEn      (btbClearEn),
    .clearAddr    (ex_pc[WIDTH-1:1])
  );

  // Next fetch address: redirect beats stall, stall beats prediction, else sequential
  always_comb begin
    nextPc = fetchPcQ + PC_STEP;
    if (mispredict)      nextPc = redirectPc;
    else if (stall)      nextPc = fetchPcQ;
    else if (pred_taken) nextPc = pred_target;
  end

  // Fetch PC register
  always_ff @(posedge clk) begin
    if (rst) fetchPcQ <= RESET_PC;
    else     fetchPcQ <= nextPc;
  end

  assign fetch_pc = fetchPcQ;
  assign flush    = mispredict;

endmodule

// File: tb/tb_branch_predict_unit.sv
module tb_branch_predict_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [15:0] fetch_pc;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_use_reg;
  logic [15:0] ex_pc;
  logic [2:0]  ex_cond;
  logic [2:0]  ex_flags;
  logic [8:0]  ex_imm;
  logic [15:0] ex_reg_target;
  logic        ex_pred_taken;
  logic [15:0] ex_pred_target;
  logic        flush;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_predict_unit #(
    .WIDTH(16), .IMM_W(9), .BTB_DEPTH(8), .RESET_PC(16'h0000)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .fetch_pc(fetch_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_use_reg(ex_use_reg),
    .ex_pc(ex_pc), .ex_cond(ex_cond), .ex_flags(ex_flags), .ex_imm(ex_imm),
    .ex_reg_target(ex_reg_target), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .flush(flush)
  );

  task automatic clearEx();
    ex_valid = 0; ex_is_branch = 0; ex_use_reg = 0; ex_pc = 0; ex_cond = 0;
    ex_flags = 0; ex_imm = 0; ex_reg_target = 0; ex_pred_taken = 0; ex_pred_target = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive an immediate branch into EX and let combinational outputs settle
  task automatic driveImm(input logic [15:0] pc, input logic [2:0] cond, input logic [2:0] flags,
                          input logic [8:0] imm, input logic pt, input logic [15:0] ptgt);
    ex_valid = 1; ex_is_branch = 1; ex_use_reg = 0; ex_pc = pc; ex_cond = cond;
    ex_flags = flags; ex_imm = imm; ex_pred_taken = pt; ex_pred_target = ptgt;
    #1;
  endtask

  // Move fetch_pc via a correctly-unpredicted register branch (never touches the BTB)
  task automatic goTo(input logic [15:0] addr);
    clearEx();
    ex_valid = 1; ex_is_branch = 1; ex_use_reg = 1; ex_pc = 16'h0F00; ex_reg_target = addr;
    step();
    clearEx();
    #1;
    checks++;
    if (fetch_pc !== addr) begin
      errors++; $display("FAIL goto_pc: got %h expected %h", fetch_pc, addr);
    end
  endtask

  task automatic test_reset();
    rst = 1; stall = 0; clearEx();
    step(); step();
    rst = 0;
    #1;
    checks++;
    if (fetch_pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h expected 0000", fetch_pc); end
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred: got %b expected 0", pred_taken); end
    checks++;
    if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b expected 0", flush); end
  endtask

  task automatic test_sequential();
    logic [15:0] exp;
    exp = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      step();
      exp = exp + 16'd2;
      checks++;
      if (fetch_pc !== exp) begin errors++; $display("FAIL seq_pc: got %h expected %h", fetch_pc, exp); end
      checks++;
      if (pred_taken !== 1'b0) begin errors++; $display("FAIL seq_pred: got %b expected 0", pred_taken); end
    end
    goTo(16'hFFFC);
    step();
    checks++;
    if (fetch_pc !== 16'hFFFE) begin errors++; $display("FAIL wrap_fffe: got %h expected fffe", fetch_pc); end
    step();
    checks++;
    if (fetch_pc !== 16'h0000) begin errors++; $display("FAIL wrap_zero: got %h expected 0000", fetch_pc); end
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL wrap_pred: got %b expected 0", pred_taken); end
  endtask

  task automatic test_taken_beq();
    goTo(16'h0010);
    driveImm(16'h0010, 3'b001, 3'b100, 9'h1FC, 1'b0, 16'h0000);
    checks++;
    if (flush !== 1'b1) begin errors++; $display("FAIL beq_flush: got %b expected 1", flush); end
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL beq_same_cycle_old: got %b expected 0", pred_taken); end
    step(); clearEx(); #1;
    checks++;
    if (flush !== 1'b0) begin errors++; $display("FAIL beq_flush_one_cycle: got %b expected 0", flush); end
    checks++;
    if (fetch_pc !== 16'h000A) begin errors++; $display("FAIL beq_redirect: got %h expected 000a", fetch_pc); end
    step(); step(); step();
    checks++;
    if (fetch_pc !== 16'h0010) begin errors++; $display("FAIL beq_refetch: got %h expected 0010", fetch_pc); end
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("FAIL beq_pred_taken: got %b expected 1", pred_taken); end
    checks++;
    if (pred_target !== 16'h000A) begin errors++; $display("FAIL beq_pred_target: got %h expected 000a", pred_target); end
    step();
    checks++;
    if (fetch_pc !== 16'h000A) begin errors++; $display("FAIL beq_follow_pred: got %h expected 000a", fetch_pc); end
  endtask

  task automatic test_not_taken();
    // 10 -> 01: mispredicted as taken
    driveImm(16'h0010, 3'b001, 3'b000, 9'h1FC, 1'b1, 16'h000A);
    checks++;
    if (flush !== 1'b1) begin errors++; $display("FAIL nt1_flush: got %b expected 1", flush); end
    step(); clearEx(); #1;
    checks++;
    if (fetch_pc !== 16'h0012) begin errors++; $display("FAIL nt1_redirect: got %h expected 0012", fetch_pc); end
    goTo(16'h0010);
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL nt1_weak_nt: got %b expected 0", pred_taken); end
    // 01 -> 00 and 00 -> 00: correctly predicted not-taken
    for (int i = 0; i < 2; i++) begin
      driveImm(16'h0010, 3'b001, 3'b000, 9'h1FC, 1'b0, 16'h0000);
      checks++;
      if (flush !== 1'b0) begin errors++; $display("FAIL nt_noflush: got %b expected 0 (iter %0d)", flush, i); end
      step(); clearEx();
    end
    // One taken from saturated 00 reaches only 01
    driveImm(16'h0010, 3'b001, 3'b100, 9'h1FC, 1'b0, 16'h0000);
    checks++;
    if (flush !== 1'b1) begin errors++; $display("FAIL sat_taken_flush: got %b expected 1", flush); end
    step(); clearEx();
    goTo(16'h0010);
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL sat_floor: got %b expected 0", pred_taken); end
    // Second taken: 01 -> 10
    driveImm(16'h0010, 3'b001, 3'b100, 9'h1FC, 1'b0, 16'h0000);
    step(); clearEx();
    goTo(16'h0010);
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("FAIL retrain_taken: got %b expected 1", pred_taken); end
    checks++;
    if (pred_target !== 16'h000A) begin errors++; $display("FAIL retrain_target: got %h expected 000a", pred_target); end
  endtask

  task automatic test_conditions();
    logic z, v, n, exp;
    for (int c = 0; c < 8; c++) begin
      for (int f = 0; f < 8; f++) begin
        z = f[2]; v = f[1]; n = f[0];
        case (c)
          0: exp = !z;
          1: exp = z;
          2: exp = !z && !n;
          3: exp = n;
          4: exp = !n;
          5: exp = n || z;
          6: exp = v;
          default: exp = 1'b1;
        endcase
        driveImm(16'h0106, 3'(c), 3'(f), 9'd4, 1'b0, 16'h0000);
        checks++;
        if (flush !== exp) begin
          errors++; $display("FAIL cond_flush: cond=%0d flags=%03b got %b expected %b", c, f[2:0], flush, exp);
        end
        step(); clearEx(); #1;
        if (exp) begin
          checks++;
          if (fetch_pc !== 16'h0110) begin
            errors++; $display("FAIL cond_redirect: cond=%0d flags=%03b got %h expected 0110", c, f[2:0], fetch_pc);
          end
        end
      end
    end
  endtask

  task automatic test_reg_branch_stall();
    goTo(16'h0010);
    stall = 1;
    ex_valid = 1; ex_is_branch = 1; ex_use_reg = 1; ex_pc = 16'h0010;
    ex_cond = 3'b000; ex_flags = 3'b100; ex_reg_target = 16'h1234;
    #1;
    checks++;
    if (flush !== 1'b1) begin errors++; $display("FAIL reg_flush: got %b expected 1", flush); end
    step(); clearEx(); #1;
    checks++;
    if (fetch_pc !== 16'h1234) begin errors++; $display("FAIL reg_over_stall: got %h expected 1234", fetch_pc); end
    step();
    checks++;
    if (fetch_pc !== 16'h1234) begin errors++; $display("FAIL stall_hold: got %h expected 1234", fetch_pc); end
    // Correctly predicted register branch: no flush
    ex_valid = 1; ex_is_branch = 1; ex_use_reg = 1; ex_pc = 16'h0040;
    ex_reg_target = 16'h1234; ex_pred_taken = 1; ex_pred_target = 16'h1234;
    #1;
    checks++;
    if (flush !== 1'b0) begin errors++; $display("FAIL reg_correct_pred: got %b expected 0", flush); end
    step(); clearEx();
    stall = 0;
    goTo(16'h0010);
    checks++;
    if (pred_taken !== 1'b1) begin errors++; $display("FAIL reg_btb_cnt: got %b expected 1", pred_taken); end
    checks++;
    if (pred_target !== 16'h000A) begin errors++; $display("FAIL reg_btb_target: got %h expected 000a", pred_target); end
  endtask

  task automatic test_alias_and_reset();
    ex_valid = 1; ex_is_branch = 0; ex_pc = 16'h0010; ex_pred_taken = 1; ex_pred_target = 16'h000A;
    #1;
    checks++;
    if (flush !== 1'b1) begin errors++; $display("FAIL alias_flush: got %b expected 1", flush); end
    step(); clearEx(); #1;
    checks++;
    if (fetch_pc !== 16'h0012) begin errors++; $display("FAIL alias_redirect: got %h expected 0012", fetch_pc); end
    goTo(16'h0010);
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL alias_invalidate: got %b expected 0", pred_taken); end
    // Fresh entry at 0x0034, then reset with conflicting inputs active
    driveImm(16'h0034, 3'b111, 3'b000, 9'd0, 1'b0, 16'h0000);
    step(); clearEx(); #1;
    checks++;
    if (fetch_pc !== 16'h0036) begin errors++; $display("FAIL always_redirect: got %h expected 0036", fetch_pc); end
    goTo(16'h0034);
    checks++;
    if (pred_taken !== 1'b1 || pred_target !== 16'h0036) begin
      errors++; $display("FAIL entry_0034: got %b/%h expected 1/0036", pred_taken, pred_target);
    end
    rst = 1; stall = 1;
    ex_valid = 1; ex_is_branch = 1; ex_use_reg = 1; ex_reg_target = 16'h5555;
    step();
    rst = 0; stall = 0; clearEx(); #1;
    checks++;
    if (fetch_pc !== 16'h0000) begin errors++; $display("FAIL midrst_pc: got %h expected 0000", fetch_pc); end
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL midrst_pred0: got %b expected 0", pred_taken); end
    goTo(16'h0034);
    checks++;
    if (pred_taken !== 1'b0) begin errors++; $display("FAIL midrst_cleared: got %b expected 0", pred_taken); end
  endtask

  initial begin
    rst = 1; stall = 0; clearEx();
    test_reset();
    test_sequential();
    test_taken_beq();
    test_not_taken();
    test_conditions();
    test_reg_branch_stall();
    test_alias_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Next-generation PC/branch unit for the pipelined core. It owns the fetch PC register and predicts the next fetch address from a direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It resolves branches arriving from EX against the condition flags and redirects fetch, asserting flush, on a misprediction. Width, immediate width and BTB depth are parameters.

## Interface
- WIDTH, 16, PC/data width
- IMM_W, 9, signed branch immediate width (word offset)
- BTB_DEPTH, 8, BTB entries; power of two, ≥2
- RESET_PC, 0, fetch PC after reset
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- stall  in  1  hold fetch_pc (hazard/memory stall)
- fetch_pc  out  WIDTH  current fetch address (registered)
- pred_taken  out  1  BTB hit with counter ≥ 2'b10 for fetch_pc
- pred_target  out  WIDTH  BTB target for fetch_pc (valid when pred_taken)
- ex_valid  in  1  EX holds a valid instruction
- ex_is_branch  in  1  EX instruction is a branch
- ex_use_reg  in  1  target comes from ex_reg_target (register branch)
- ex_pc  in  WIDTH  PC of the EX instruction
- ex_cond  in  3  condition code
- ex_flags  in  3  {Z,V,N}: bit2 Z, bit1 V, bit0 N
- ex_imm  in  IMM_W  signed word offset
- ex_reg_target  in  WIDTH  register target
- ex_pred_taken  in  1  prediction carried down the pipe with this instruction
- ex_pred_target  in  WIDTH  predicted target carried down the pipe
- flush  out  1  combinational misprediction; kill IF/ID

## Operation
- Conditions: 000 NE ~Z; 001 EQ Z; 010 GT ~Z&~N; 011 LT N; 100 GE ~N; 101 LE N|Z; 110 OV V; 111 always.
- seq = ex_pc+2. For immediate branches, target = seq + (sign-extended ex_imm << 1), mod 2^WIDTH. For register branches, target = ex_reg_target. Register branches are always taken, regardless of ex_cond.
- actual_taken = ex_valid & ex_is_branch & cond_true.
- mispredict = ex_valid & ex_is_branch & (actual_taken≠ex_pred_taken | (actual_taken & target≠ex_pred_target)). A non-branch with ex_pred_taken=1 also mispredicts (aliasing), with redirect to seq.
- flush = mispredict. Redirect address = actual_taken ? target : seq.
- Next fetch_pc priority:
  1. rst → RESET_PC.
  2. mispredict → redirect. This overrides stall.
  3. stall → hold.
  4. pred_taken → pred_target.
  5. Otherwise fetch_pc+2, wrapping.
- BTB addressing: index = pc[log2(BTB_DEPTH):1]; tag = pc[WIDTH-1:log2(BTB_DEPTH)+1]. Entry fields: valid, tag, target, 2-bit counter. Counter states: 00 SNT, 01 WNT, 10 WT, 11 ST.
- BTB lookup is combinational on fetch_pc. Hit = valid & tag match.
- BTB update occurs when ex_valid & ex_is_branch & ~ex_use_reg:
  - Hit: counter ±1, saturating at 11 and 00. Target is rewritten when taken.
  - Miss and taken: allocate the entry (overwrite) with counter 10.
  - Miss and not taken: no write.
- Register branches never update the BTB. A non-branch that mispredicts clears the valid bit of the entry at its index.

## Timing
- Reset: fetch_pc=RESET_PC, all valid bits 0, so pred_taken=0 and flush=0 when ex_valid=0.
- Prediction latency is 0 cycles: pred_* follows fetch_pc combinationally.
- Redirect latency: fetch_pc = redirect on the edge after the mispredict cycle. flush is high only in that cycle.
- A BTB write lands at the edge. A lookup in the same cycle at the same index sees the old contents.
- Simultaneous mispredict and stall: redirect wins. The BTB update still occurs.
- rst mid-operation clears everything on the next edge, regardless of other inputs.
- Flags and ex_* are sampled only in the cycle ex_valid=1. There is no hold requirement beyond that cycle.

## Structure
- Package branch_pkg holds:
  - condition-code constants (COND_NE … COND_ALWAYS);
  - counter state constants;
  - a cond_eval function (cond, flags) → bit.
- Sub-module branch_target_buffer(WIDTH, BTB_DEPTH): lookup port plus one write port. It owns the counters and the clear operation.
- The top level holds the PC register, target arithmetic, mispredict logic and next-PC mux.

## Test plan
- Reset, then no branches: fetch_pc steps 0,2,4…; at 0xFFFE it wraps to 0x0000; pred_taken stays 0.
- Taken BEQ at pc 0x0010, imm=-4 (target 0x000A), Z=1, pred 0: flush=1 for one cycle, next fetch_pc=0x000A. BTB entry is allocated with counter 10. The next fetch of 0x0010 gives pred_taken=1 and pred_target=0x000A.
- Same branch not taken twice (Z=0): counter goes 10→01 (mispredict, flush, redirect 0x0012), then 01→00 (no flush). A third resolution also gives 00, confirming saturation.
- All 8 conditions across all 8 flag combinations with pred 0: flush equals the expected truth value, e.g. LE with N=0, Z=1 → taken.
- Register branch, ex_reg_target=0x1234, while stall=1: flush=1, fetch_pc=0x1234 next cycle despite the stall, and the BTB is unchanged.
- BTB aliasing: a non-branch with ex_pred_taken=1 gives flush=1 and redirect to ex_pc+2, and the entry at its index is invalidated. rst asserted mid-sequence restores fetch_pc=0 and clears all hits.
